// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noc_pkg
//  Description : Shared HSR NoC flit definitions: field widths, field offsets
//                and the packed flit struct used by router and arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

  localparam int NOC_PAYLOAD_W = 16;
  localparam int NOC_ADDR_W    = 4;
  localparam int NOC_TGT_W     = 3;
  localparam int NOC_FLIT_W    = NOC_PAYLOAD_W + NOC_ADDR_W + NOC_TGT_W;

  // Field offsets inside a flit; the target occupies the LSBs
  localparam int NOC_TGT_LSB     = 0;
  localparam int NOC_ADDR_LSB    = NOC_TGT_W;
  localparam int NOC_PAYLOAD_LSB = NOC_TGT_W + NOC_ADDR_W;

  typedef struct packed {
    logic [NOC_PAYLOAD_W-1:0] payload;
    logic [NOC_ADDR_W-1:0]    addr;
    logic [NOC_TGT_W-1:0]     target;
  } noc_flit_t;

endpackage : noc_pkg
`default_nettype wire

// File: rtl/noc_fifo_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : noc_fifo_ptr
//  Description : Circular buffer pointer that wraps to zero after DEPTH-1.
//                Works for any DEPTH >= 2, not only powers of two.
//  Revision    : 1.0 - initial release
// ============================================================================
module noc_fifo_ptr #(
  parameter int DEPTH = 6,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [PTR_W-1:0] o_ptr
);

  localparam logic [PTR_W-1:0] C_LAST = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] r_ptr;

  // Advance on enable; explicit compare gives wrap at DEPTH-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= (r_ptr == C_LAST) ? '0 : r_ptr + PTR_W'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule : noc_fifo_ptr
`default_nettype wire

// File: rtl/noc_input_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : noc_input_fifo
//  Description : Router input buffer. Circular FIFO of DEPTH flits with head
//                field split, status, credit return and sticky error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module noc_input_fifo
  import noc_pkg::*;
#(
  parameter int PAYLOAD_W = NOC_PAYLOAD_W,
  parameter int ADDR_W    = NOC_ADDR_W,
  parameter int TGT_W     = NOC_TGT_W,
  parameter int FLIT_W    = PAYLOAD_W + ADDR_W + TGT_W,
  parameter int DEPTH     = 6,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_W-1:0]    data,
  input  logic                 valid,
  input  logic                 pop,
  input  logic                 clear_err,
  output logic [FLIT_W-1:0]    out,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] head_payload,
  output logic [ADDR_W-1:0]    head_addr,
  output logic [TGT_W-1:0]     head_target,
  output logic                 full,
  output logic                 empty,
  output logic [CNT_W-1:0]     count,
  output logic                 credit_return,
  output logic                 overflow_err,
  output logic                 underflow_err
);

  localparam int               C_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [FLIT_W-1:0]  r_mem [DEPTH];
  logic [CNT_W-1:0]   r_count;
  logic               r_credit;
  logic               r_ovf;
  logic               r_unf;
  logic [C_PTR_W-1:0] w_rd_ptr;
  logic [C_PTR_W-1:0] w_wr_ptr;
  logic               w_full;
  logic               w_empty;
  logic               w_pop_ok;
  logic               w_push_ok;
  logic               w_ovf_evt;
  logic               w_unf_evt;

  // Status comes from the registered count only, so it never glitches on inputs
  assign w_full    = (r_count == C_DEPTH);
  assign w_empty   = (r_count == '0);
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push with a pop
  assign w_pop_ok  = pop & ~w_empty;
  assign w_push_ok = valid & (~w_full | w_pop_ok);
  assign w_ovf_evt = valid & ~w_push_ok;
  assign w_unf_evt = pop & w_empty;

  noc_fifo_ptr #(.DEPTH(DEPTH), .PTR_W(C_PTR_W)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_pop_ok),
    .o_ptr (w_rd_ptr)
  );

  noc_fifo_ptr #(.DEPTH(DEPTH), .PTR_W(C_PTR_W)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_push_ok),
    .o_ptr (w_wr_ptr)
  );

  // Storage: cleared on reset, written at wr_ptr on an accepted push; popped entries keep their data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push_ok) begin
      r_mem[w_wr_ptr] <= data;
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_push_ok && !w_pop_ok) begin
      r_count <= r_count + CNT_W'(1);
    end else if (w_pop_ok && !w_push_ok) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  // Credit pulse and sticky error flags; a new error event beats clear_err
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credit <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_credit <= w_pop_ok;
      r_ovf    <= w_ovf_evt | (r_ovf & ~clear_err);
      r_unf    <= w_unf_evt | (r_unf & ~clear_err);
    end
  end

  assign out           = w_empty ? '0 : r_mem[w_rd_ptr];
  assign out_valid     = ~w_empty;
  assign head_payload  = out[FLIT_W-1 -: PAYLOAD_W];
  assign head_addr     = out[TGT_W +: ADDR_W];
  assign head_target   = out[TGT_W-1:0];
  assign full          = w_full;
  assign empty         = w_empty;
  assign count         = r_count;
  assign credit_return = r_credit;
  assign overflow_err  = r_ovf;
  assign underflow_err = r_unf;

endmodule : noc_input_fifo
`default_nettype wire

// File: tb/tb_noc_input_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_noc_input_fifo
//  Description : Self-checking bench for noc_input_fifo against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_input_fifo;

  localparam int DEPTH  = 6;
  localparam int FLIT_W = 23;
  localparam int CNT_W  = 3;

  logic              clk;
  logic              rst;
  logic [FLIT_W-1:0] data;
  logic              valid;
  logic              pop;
  logic              clear_err;
  logic [FLIT_W-1:0] out;
  logic              out_valid;
  logic [15:0]       head_payload;
  logic [3:0]        head_addr;
  logic [2:0]        head_target;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              credit_return;
  logic              overflow_err;
  logic              underflow_err;

  noc_input_fifo #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .data          (data),
    .valid         (valid),
    .pop           (pop),
    .clear_err     (clear_err),
    .out           (out),
    .out_valid     (out_valid),
    .head_payload  (head_payload),
    .head_addr     (head_addr),
    .head_target   (head_target),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .credit_return (credit_return),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [FLIT_W-1:0] m_q[$];
  logic              m_credit;
  logic              m_ovf;
  logic              m_unf;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_credit = 1'b0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
  endtask

  task automatic check_all();
    logic [FLIT_W-1:0] e_out;
    e_out = (m_q.size() > 0) ? m_q[0] : '0;
    check_eq("out",           64'(out),           64'(e_out));
    check_eq("out_valid",     64'(out_valid),     64'(m_q.size() > 0));
    check_eq("head_payload",  64'(head_payload),  64'(e_out[22:7]));
    check_eq("head_addr",     64'(head_addr),     64'(e_out[6:3]));
    check_eq("head_target",   64'(head_target),   64'(e_out[2:0]));
    check_eq("count",         64'(count),         64'(m_q.size()));
    check_eq("full",          64'(full),          64'(m_q.size() == DEPTH));
    check_eq("empty",         64'(empty),         64'(m_q.size() == 0));
    check_eq("credit_return", 64'(credit_return), 64'(m_credit));
    check_eq("overflow_err",  64'(overflow_err),  64'(m_ovf));
    check_eq("underflow_err", 64'(underflow_err), 64'(m_unf));
  endtask

  // One clock cycle with the given inputs; model follows FIFO rules, then all outputs compared
  task automatic step(input logic v, input logic [FLIT_W-1:0] d, input logic p, input logic c);
    int  sz;
    bit  pop_ok;
    bit  push_ok;
    valid     = v;
    data      = d;
    pop       = p;
    clear_err = c;
    sz      = m_q.size();
    pop_ok  = p && (sz > 0);
    push_ok = v && ((sz < DEPTH) || pop_ok);
    @(posedge clk);
    if (pop_ok)  void'(m_q.pop_front());
    if (push_ok) m_q.push_back(d);
    m_credit = pop_ok;
    m_ovf    = (v && !push_ok) ? 1'b1 : (c ? 1'b0 : m_ovf);
    m_unf    = (p && sz == 0)  ? 1'b1 : (c ? 1'b0 : m_unf);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; pop = 1'b0; clear_err = 1'b0; data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Fill to full with 1..6
    for (int i = 1; i <= DEPTH; i++) step(1'b1, FLIT_W'(i), 1'b0, 1'b0);
    // Overflow push, then drain
    step(1'b1, 23'h7FFFFF, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    // Push plus pop on empty
    step(1'b1, 23'h12345A, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    // Refill, then push with pop while full, then drain through the wrap
    for (int i = 0; i < DEPTH - 1; i++) step(1'b1, FLIT_W'(8'h20 + i), 1'b0, 1'b0);
    step(1'b1, 23'h0000AA, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
    // Clear alone, then re-create overflow and clear together with a new overflow
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, FLIT_W'(8'h40 + i), 1'b0, 1'b0);
    step(1'b1, 23'h111111, 1'b0, 1'b0);
    step(1'b1, 23'h222222, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset with 3 entries stored
    for (int i = 0; i < 3; i++) step(1'b1, FLIT_W'(8'h60 + i), 1'b0, 1'b0);
    valid = 1'b0; pop = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_out",   64'(out),   64'h0);
    check_eq("async_rst_empty", 64'(empty), 64'h1);
    check_eq("async_rst_count", 64'(count), 64'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();
    step(1'b1, 23'h5A5A5A, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Randomized phases: push-heavy, pop-heavy, balanced
    for (int ph = 0; ph < 3; ph++) begin
      for (int n = 0; n < 150; n++) begin
        int pv;
        int pp;
        pv = (ph == 0) ? 80 : (ph == 1) ? 25 : 50;
        pp = (ph == 0) ? 25 : (ph == 1) ? 80 : 50;
        step(($urandom_range(99) < pv), FLIT_W'($urandom), ($urandom_range(99) < pp),
             ($urandom_range(99) < 10));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_noc_input_fifo
`default_nettype wire
